mem_model_mp: RTL and testbench

- Parametrised multi-port simulation memory. Successor to the fixed 2-read/1-write, 1-cycle, always-ready fake SRAM in the top-level system.
- Sits between core fetch/load/store ports and a behavioural storage array.
- Adds N read ports, programmable read latency, per-port response backpressure with credit-based acceptance, and byte-strobed writes.

---
 rtl/mem_model_pkg.sv | 22 ++
 rtl/mem_resp_fifo.sv | 64 ++++++
 rtl/mem_model_mp.sv | 123 ++++++++++++
 tb/tb_mem_model_mp.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_model_pkg.sv
// Shared constants, payload types and helpers for the multi-port simulation memory.
package mem_model_pkg;

    localparam int unsigned XLEN           = 64;
    localparam int unsigned DATA_WIDTH_DEF = 64;
    localparam int unsigned STRB_W         = DATA_WIDTH_DEF / 8;
    localparam int unsigned OFF_BITS       = $clog2(STRB_W);

    typedef logic [DATA_WIDTH_DEF-1:0] word_t;
    typedef logic [STRB_W-1:0]         strb_t;

    typedef struct packed {
        logic  valid;
        word_t data;
    } rd_pipe_t;

    // Byte-offset bits inside one word of the given width.
    function automatic int unsigned off_bits(input int unsigned data_width);
        return $clog2(data_width / 8);
    endfunction

endpackage

// File: rtl/mem_resp_fifo.sv
// Fall-through response FIFO: an entry pushed into an empty FIFO is visible in the same cycle.
module mem_resp_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 64
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic                       valid_c,
    output logic [WIDTH-1:0]           data_c,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] buf_q [DEPTH];
    logic [PTR_W-1:0] rptr_q;
    logic [PTR_W-1:0] wptr_q;
    logic [CNT_W-1:0] cnt_q;
    logic             empty_c;
    logic             store_c;
    logic             take_c;

    always_comb begin
        empty_c = (cnt_q == '0);
        valid_c = !empty_c || push;
        data_c  = empty_c ? din : buf_q[rptr_q];
        // A push that is consumed in the same cycle bypasses storage.
        store_c = push && !(empty_c && pop);
        take_c  = pop && !empty_c;
    end

    assign count = cnt_q;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            rptr_q <= '0;
            wptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (store_c) begin
                wptr_q <= (wptr_q == PTR_W'(DEPTH - 1)) ? '0 : wptr_q + PTR_W'(1);
            end
            if (take_c) begin
                rptr_q <= (rptr_q == PTR_W'(DEPTH - 1)) ? '0 : rptr_q + PTR_W'(1);
            end
            case ({store_c, take_c})
                2'b10:   cnt_q <= cnt_q + CNT_W'(1);
                2'b01:   cnt_q <= cnt_q - CNT_W'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (store_c) begin
            buf_q[wptr_q] <= din;
        end
    end

endmodule

// File: rtl/mem_model_mp.sv
// Multi-port behavioural memory: N credit-limited read ports with fixed latency and one
// byte-strobed write port.
module mem_model_mp
    import mem_model_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 20,
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned NB_RPORTS  = 2,
    parameter int unsigned LATENCY    = 1,
    parameter int unsigned RESP_DEPTH = 2
) (
    input  logic                                 clk,
    input  logic                                 rstn,
    input  logic [NB_RPORTS-1:0]                 rd_a_valid,
    output logic [NB_RPORTS-1:0]                 rd_a_ready,
    input  logic [NB_RPORTS-1:0][XLEN-1:0]       rd_a_addr,
    output logic [NB_RPORTS-1:0]                 rd_d_valid,
    input  logic [NB_RPORTS-1:0]                 rd_d_ready,
    output logic [NB_RPORTS-1:0][DATA_WIDTH-1:0] rd_d_data,
    input  logic                                 wr_valid,
    output logic                                 wr_ready,
    input  logic [XLEN-1:0]                      wr_addr,
    input  logic [DATA_WIDTH-1:0]                wr_data,
    input  logic [DATA_WIDTH/8-1:0]              wr_strb
);

    localparam int unsigned STRB_N = DATA_WIDTH / 8;
    localparam int unsigned OFF_W  = off_bits(DATA_WIDTH);
    localparam int unsigned WORDS  = 2 ** ADDR_WIDTH;
    localparam int unsigned CNT_W  = $clog2(RESP_DEPTH + 1);

    logic [DATA_WIDTH-1:0] mem_q [WORDS];
    logic                  init_q;
    logic [CNT_W-1:0]      outstanding_q [NB_RPORTS];
    logic [LATENCY-1:0]    pipe_valid_q  [NB_RPORTS];
    logic [DATA_WIDTH-1:0] pipe_data_q   [NB_RPORTS][LATENCY];
    logic [CNT_W-1:0]      count_unused  [NB_RPORTS];

    logic [NB_RPORTS-1:0]  accept_c;
    logic [NB_RPORTS-1:0]  resp_hs_c;
    logic [ADDR_WIDTH-1:0] rd_idx_c [NB_RPORTS];
    logic [ADDR_WIDTH-1:0] wr_idx_c;
    logic                  wr_hs_c;
    logic                  unused_bits;

    // Offset bits and bits above the index field are ignored; addresses alias.
    assign unused_bits = ^{rd_a_addr, wr_addr};

    always_comb begin
        wr_ready = init_q;
        wr_hs_c  = wr_valid && init_q;
        wr_idx_c = wr_addr[OFF_W +: ADDR_WIDTH];
        for (int p = 0; p < NB_RPORTS; p++) begin
            rd_a_ready[p] = init_q && (outstanding_q[p] < CNT_W'(RESP_DEPTH));
            accept_c[p]   = rd_a_valid[p] && rd_a_ready[p];
            resp_hs_c[p]  = rd_d_valid[p] && rd_d_ready[p];
            rd_idx_c[p]   = rd_a_addr[p][OFF_W +: ADDR_WIDTH];
        end
    end

    // Control state: startup flag, credit counters and pipeline valids.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            init_q <= 1'b0;
            for (int p = 0; p < NB_RPORTS; p++) begin
                outstanding_q[p] <= '0;
                pipe_valid_q[p]  <= '0;
            end
        end else begin
            init_q <= 1'b1;
            for (int p = 0; p < NB_RPORTS; p++) begin
                case ({accept_c[p], resp_hs_c[p]})
                    2'b10:   outstanding_q[p] <= outstanding_q[p] + CNT_W'(1);
                    2'b01:   outstanding_q[p] <= outstanding_q[p] - CNT_W'(1);
                    default: outstanding_q[p] <= outstanding_q[p];
                endcase
                pipe_valid_q[p][0] <= accept_c[p];
                for (int s = 1; s < LATENCY; s++) begin
                    pipe_valid_q[p][s] <= pipe_valid_q[p][s-1];
                end
            end
        end
    end

    // Read data is captured at the accept edge, before any same-edge write lands.
    always_ff @(posedge clk) begin
        for (int p = 0; p < NB_RPORTS; p++) begin
            if (accept_c[p]) begin
                pipe_data_q[p][0] <= mem_q[rd_idx_c[p]];
            end
            for (int s = 1; s < LATENCY; s++) begin
                pipe_data_q[p][s] <= pipe_data_q[p][s-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_hs_c) begin
            for (int b = 0; b < STRB_N; b++) begin
                if (wr_strb[b]) begin
                    mem_q[wr_idx_c][b*8 +: 8] <= wr_data[b*8 +: 8];
                end
            end
        end
    end

    for (genvar gp = 0; gp < NB_RPORTS; gp++) begin : g_port
        mem_resp_fifo #(
            .DEPTH (RESP_DEPTH),
            .WIDTH (DATA_WIDTH)
        ) u_fifo (
            .clk     (clk),
            .rstn    (rstn),
            .push    (pipe_valid_q[gp][LATENCY-1]),
            .din     (pipe_data_q[gp][LATENCY-1]),
            .pop     (rd_d_ready[gp]),
            .valid_c (rd_d_valid[gp]),
            .data_c  (rd_d_data[gp]),
            .count   (count_unused[gp])
        );
    end

endmodule

// File: tb/tb_mem_model_mp.sv
// Directed bench for mem_model_mp: a LATENCY=1 instance for function/credit/reset
// and a LATENCY=3 instance for pipelined two-port timing.
module tb_mem_model_mp;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    logic [1:0]        r1_a_valid, r1_a_ready, r1_d_valid, r1_d_ready;
    logic [1:0][63:0]  r1_a_addr, r1_d_data;
    logic              w1_valid, w1_ready;
    logic [63:0]       w1_addr, w1_data;
    logic [7:0]        w1_strb;

    logic [1:0]        r3_a_valid, r3_a_ready, r3_d_valid, r3_d_ready;
    logic [1:0][63:0]  r3_a_addr, r3_d_data;
    logic              w3_valid, w3_ready;
    logic [63:0]       w3_addr, w3_data;
    logic [7:0]        w3_strb;

    int n_checks = 0;
    int n_errors = 0;

    mem_model_mp #(.ADDR_WIDTH(10), .DATA_WIDTH(64), .NB_RPORTS(2), .LATENCY(1), .RESP_DEPTH(2)) u_dut1 (
        .clk(clk), .rstn(rstn),
        .rd_a_valid(r1_a_valid), .rd_a_ready(r1_a_ready), .rd_a_addr(r1_a_addr),
        .rd_d_valid(r1_d_valid), .rd_d_ready(r1_d_ready), .rd_d_data(r1_d_data),
        .wr_valid(w1_valid), .wr_ready(w1_ready), .wr_addr(w1_addr),
        .wr_data(w1_data), .wr_strb(w1_strb)
    );

    mem_model_mp #(.ADDR_WIDTH(10), .DATA_WIDTH(64), .NB_RPORTS(2), .LATENCY(3), .RESP_DEPTH(4)) u_dut3 (
        .clk(clk), .rstn(rstn),
        .rd_a_valid(r3_a_valid), .rd_a_ready(r3_a_ready), .rd_a_addr(r3_a_addr),
        .rd_d_valid(r3_d_valid), .rd_d_ready(r3_d_ready), .rd_d_data(r3_d_data),
        .wr_valid(w3_valid), .wr_ready(w3_ready), .wr_addr(w3_addr),
        .wr_data(w3_data), .wr_strb(w3_strb)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr1(input logic [63:0] addr, input logic [63:0] data, input logic [7:0] strb);
        w1_valid = 1'b1;
        w1_addr  = addr;
        w1_data  = data;
        w1_strb  = strb;
        tick();
        w1_valid = 1'b0;
    endtask

    // Single read on dut1 with response ready: response must show the cycle after accept.
    task automatic rd1(input int p, input logic [63:0] addr, input logic [63:0] exp, input string tag);
        check({tag, "_ready"}, 64'(r1_a_ready[p]), 64'd1);
        r1_a_valid[p] = 1'b1;
        r1_a_addr[p]  = addr;
        tick();
        r1_a_valid[p] = 1'b0;
        check({tag, "_valid"}, 64'(r1_d_valid[p]), 64'd1);
        check({tag, "_data"}, r1_d_data[p], exp);
        tick();
    endtask

    int acc;
    logic [63:0] exp0, exp1;

    initial begin
        rstn = 1'b0;
        r1_a_valid = '0; r1_a_addr = '0; r1_d_ready = 2'b11;
        w1_valid = 1'b0; w1_addr = '0; w1_data = '0; w1_strb = '0;
        r3_a_valid = '0; r3_a_addr = '0; r3_d_ready = 2'b11;
        w3_valid = 1'b0; w3_addr = '0; w3_data = '0; w3_strb = '0;

        tick();
        tick();
        check("rst_rd_a_ready", 64'(r1_a_ready), 64'd0);
        check("rst_wr_ready", 64'(w1_ready), 64'd0);
        check("rst_rd_d_valid", 64'(r1_d_valid), 64'd0);
        rstn = 1'b1;
        check("startup_rd_a_ready", 64'(r1_a_ready), 64'd0);
        check("startup_wr_ready", 64'(w1_ready), 64'd0);
        tick();
        check("init_rd_a_ready", 64'(r1_a_ready), 64'd3);
        check("init_wr_ready", 64'(w1_ready), 64'd1);
        check("init3_rd_a_ready", 64'(r3_a_ready), 64'd3);

        // Full-strobe write then read back.
        wr1(64'h100, 64'h1122334455667788, 8'hFF);
        rd1(0, 64'h100, 64'h1122334455667788, "full_wr");
        check("full_wr_after", 64'(r1_d_valid), 64'd0);

        // Partial strobes and the no-op strobe.
        wr1(64'h100, 64'hFFFFFFFFFFFFFFFF, 8'hFF);
        wr1(64'h100, 64'h0, 8'h0F);
        rd1(0, 64'h100, 64'hFFFFFFFF00000000, "strb_0f");
        wr1(64'h100, 64'h0, 8'h00);
        rd1(1, 64'h100, 64'hFFFFFFFF00000000, "strb_00");
        // Offset bits ignored: 0x105 aliases word 0x100.
        rd1(0, 64'h105, 64'hFFFFFFFF00000000, "offset_alias");

        // Credit throttling on port 1.
        wr1(64'h300, 64'h1111000000000001, 8'hFF);
        wr1(64'h308, 64'h1111000000000002, 8'hFF);
        wr1(64'h310, 64'h1111000000000003, 8'hFF);
        r1_d_ready[1] = 1'b0;
        r1_a_valid[1] = 1'b1;
        r1_a_addr[1]  = 64'h300;
        acc = 0;
        for (int c = 0; c < 5; c++) begin
            if (r1_a_ready[1]) acc++;
            tick();
            r1_a_addr[1] = 64'h300 + 64'(8 * acc);
        end
        check("credit_accepts", 64'(acc), 64'd2);
        check("credit_ready_low", 64'(r1_a_ready[1]), 64'd0);
        check("credit_valid_held", 64'(r1_d_valid[1]), 64'd1);
        check("credit_data_a", r1_d_data[1], 64'h1111000000000001);
        r1_d_ready[1] = 1'b1;
        tick();
        check("credit_data_b", r1_d_data[1], 64'h1111000000000002);
        check("credit_ready_back", 64'(r1_a_ready[1]), 64'd1);
        tick();
        r1_a_valid[1] = 1'b0;
        check("credit_third_valid", 64'(r1_d_valid[1]), 64'd1);
        check("credit_data_c", r1_d_data[1], 64'h1111000000000003);
        tick();
        check("credit_drained", 64'(r1_d_valid[1]), 64'd0);

        // Same-cycle read/write collision returns the pre-write value.
        wr1(64'h200, 64'h5555555555555555, 8'hFF);
        w1_valid = 1'b1; w1_addr = 64'h200; w1_data = 64'hAAAAAAAAAAAAAAAA; w1_strb = 8'hFF;
        r1_a_valid[0] = 1'b1; r1_a_addr[0] = 64'h200;
        tick();
        w1_valid = 1'b0;
        check("coll_old_valid", 64'(r1_d_valid[0]), 64'd1);
        check("coll_old_data", r1_d_data[0], 64'h5555555555555555);
        tick();
        r1_a_valid[0] = 1'b0;
        check("coll_new_data", r1_d_data[0], 64'hAAAAAAAAAAAAAAAA);
        tick();

        // LATENCY=3 instance: port 0 reads words 0..3, port 1 reads 3..0, back to back.
        for (int k = 0; k < 4; k++) begin
            w3_valid = 1'b1;
            w3_addr  = 64'h400 + 64'(8 * k);
            w3_data  = 64'hC0DE000000000000 + 64'(k);
            w3_strb  = 8'hFF;
            tick();
        end
        w3_valid = 1'b0;
        for (int t = 0; t < 8; t++) begin
            if (t < 4) check($sformatf("lat3_ready_t%0d", t), 64'(r3_a_ready), 64'd3);
            check($sformatf("lat3_valid_t%0d", t), 64'(r3_d_valid),
                  (t >= 3 && t <= 6) ? 64'd3 : 64'd0);
            if (t >= 3 && t <= 6) begin
                exp0 = 64'hC0DE000000000000 + 64'(t - 3);
                exp1 = 64'hC0DE000000000000 + 64'(6 - t);
                check($sformatf("lat3_p0_data_t%0d", t), r3_d_data[0], exp0);
                check($sformatf("lat3_p1_data_t%0d", t), r3_d_data[1], exp1);
            end
            if (t < 4) begin
                r3_a_valid   = 2'b11;
                r3_a_addr[0] = 64'h400 + 64'(8 * t);
                r3_a_addr[1] = 64'h400 + 64'(8 * (3 - t));
            end else begin
                r3_a_valid = 2'b00;
            end
            tick();
        end

        // Reset with two reads queued on port 0.
        r1_d_ready[0] = 1'b0;
        r1_a_valid[0] = 1'b1;
        r1_a_addr[0]  = 64'h100;
        tick();
        tick();
        r1_a_valid[0] = 1'b0;
        check("pre_rst_valid", 64'(r1_d_valid[0]), 64'd1);
        rstn = 1'b0;
        tick();
        check("midrst_rd_d_valid", 64'(r1_d_valid), 64'd0);
        check("midrst_rd_a_ready", 64'(r1_a_ready), 64'd0);
        check("midrst_wr_ready", 64'(w1_ready), 64'd0);
        rstn = 1'b1;
        check("release_rd_a_ready", 64'(r1_a_ready), 64'd0);
        check("release_wr_ready", 64'(w1_ready), 64'd0);
        check("release3_rd_a_ready", 64'(r3_a_ready), 64'd0);
        r1_d_ready = 2'b11;
        tick();
        check("post_rst_rd_d_valid", 64'(r1_d_valid), 64'd0);
        check("post_rst_ready", 64'(r1_a_ready), 64'd3);
        tick();
        check("post_rst_no_resp", 64'(r1_d_valid), 64'd0);
        rd1(1, 64'h200, 64'hAAAAAAAAAAAAAAAA, "post_rst_read");
        rd1(0, 64'h310, 64'h1111000000000003, "post_rst_read2");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
